snake_game_ctrl: RTL and testbench
==================================

Name: snake_game_ctrl

Overview:
- Game-sequencing controller that consumes the registered collision, button and direction levels produced by the input synchroniser stage.
- Runs the top-level game state machine (idle/run/pause/over) and queues player turns with reversal rejection.
- Issues one snake step per game tick and maintains the score.
- Sits between the input synchroniser and the snake body/position datapath.

Parameters:
QDEPTH, 2, depth of pending-turn queue (>=1)
SCORE_W, 8, score counter width
INIT_DIR, 4'b0001, heading loaded at reset and on game restart (one-hot)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
goodColl_i  in  1  registered food-collision level
badColl_i  in  1  registered wall/self-collision level
button_i  in  1  registered start/pause button level
direction_i  in  4  registered one-hot direction level; [3]=up [2]=down [1]=left [0]=right
tick_i  in  1  one-cycle game-rate strobe
dir_o  out  4  current heading, one-hot
step_o  out  1  one-cycle pulse: advance snake one cell in dir_o
grow_o  out  1  qualifies step_o: snake grows on this step
score_o  out  SCORE_W  food count, saturating
state_o  out  2  IDLE=0 RUN=1 PAUSE=2 OVER=3

Behaviour:
- Reset is synchronous, active-high, one clk. It takes precedence over everything, including mid-game.
  - Reset values: state IDLE, dir_o=INIT_DIR, step_o=0, grow_o=0, score_o=0, queue empty, grow latch 0, edge-history registers 0.
- Internal edge detection: each input is registered once more.
  - btn_rise = button_i & ~prev.
  - food_rise = goodColl_i & ~prev.
  - dir_evt = direction_i is one-hot AND direction_i != prev direction_i.
  - Non-one-hot direction_i (0 or multi-bit) never generates an event.
- FSM, evaluated in this priority order:
  - IDLE: btn_rise -> RUN; score cleared, queue cleared, dir_o=INIT_DIR.
  - RUN: badColl_i=1 -> OVER (beats tick and button in the same cycle). Else btn_rise -> PAUSE.
  - PAUSE: btn_rise -> RUN. Collisions ignored.
  - OVER: btn_rise -> IDLE. score_o holds until that transition. Queue cleared on entering OVER.
- Turn queue (FIFO, QDEPTH entries):
  - Push only in RUN, on dir_evt.
  - Reference heading = queue tail if count>0, else dir_o.
  - Reject (silently drop) if the new direction equals the reference or is its reverse (up<->down, left<->right).
  - Reject if full, unless a pop occurs in the same cycle; in that case the push is accepted.
- Step sequencing: tick_i in RUN with no badColl_i that cycle triggers a step.
  - At the next edge: step_o=1 for exactly one cycle.
  - dir_o <= queue head (popped) if non-empty, else unchanged.
  - Latency is 1 cycle from tick_i to step_o. dir_o is valid in the same cycle as step_o.
  - tick_i in IDLE/PAUSE/OVER is ignored; no step, no pop.
- Simultaneous pop and push: pop first, then push against the post-pop tail.
  - With count=1, the reference is the popped head, which becomes the new dir_o.
- Food:
  - food_rise in RUN increments score_o, saturating at 2^SCORE_W-1 (no wrap).
  - food_rise in RUN also sets the grow latch.
  - grow_o = grow latch on the step_o cycle; the latch clears on that step.
  - food_rise coincident with a tick sets the latch after that step's sample, so grow applies to the following step.
- All outputs are registered.

Decomposition:
- Shared package snake_pkg:
  - state_t enum (IDLE/RUN/PAUSE/OVER, 2-bit)
  - DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT one-hot constants
  - function dir_reverse(dir) and function is_onehot(v)
- Sub-module dir_fifo:
  - parameterised depth/width, synchronous FIFO with push, pop, head, tail, count, full, empty.
  - Supports simultaneous push/pop when full.
  - Reset via rst.

Test Plan:
- Reset, then button pulse, then tick -> state_o=RUN one cycle after btn_rise; step_o=1 one cycle after tick with dir_o=0001; score_o=0.
- RUN, dir_o=right: press up then left before a tick, then tick, tick -> steps with dir_o=1000 then 0010; queue empty after.
- RUN, dir_o=right: press left (reverse) and re-press right -> both dropped; next tick step_o=1, dir_o=0001.
- QDEPTH=2: three distinct legal turns up, left, down with no tick -> third dropped. Then a tick coinciding with a new push of up is accepted (pop+push when full).
- goodColl_i pulse twice in RUN, then tick -> score_o=2, grow_o=1 on the first step only. SCORE_W=2 with 5 food events -> score_o saturates at 3.
- badColl_i and tick_i in the same cycle -> state_o=OVER, no step_o. Button -> IDLE with score cleared. Assert rst mid-RUN -> all reset values on the next cycle.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types, heading constants and helpers for the snake game controller.
package snake_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    // Opposite heading; non-one-hot input maps to zero, which never matches a stored heading.
    function automatic logic [3:0] dir_reverse(input logic [3:0] dir);
        logic [3:0] r;
        r = 4'b0000;
        case (dir)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
            default:   r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/snake_game_ctrl_dir_fifo.sv
// Small synchronous FIFO holding pending turns; a pop and push in the same
// cycle are both honoured even when full. Synchronous clear empties it.
module dir_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic [WIDTH-1:0] tail_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q, last_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == CW'(DEPTH));
    assign do_pop   = pop_i & ~empty_o;
    assign do_push  = push_i & (~full_o | do_pop);
    assign last_ptr = (wr_ptr_q == '0) ? PW'(DEPTH - 1) : wr_ptr_q - 1'b1;
    assign head_o   = mem_q[rd_ptr_q];
    assign tail_o   = mem_q[last_ptr];
    assign count_o  = count_q;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage; contents are only meaningful below count_q, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Game sequencing: start/pause/over FSM, queued turns with reversal
// rejection, one step per game tick, saturating food score.
//
//  state | meaning
//  IDLE  | waiting for button to start a game
//  RUN   | game active; ticks step the snake, turns and food accepted
//  PAUSE | frozen; ticks and collisions ignored
//  OVER  | crashed; score held until button returns to IDLE
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int         QDEPTH   = 2,
    parameter int         SCORE_W  = 8,
    parameter logic [3:0] INIT_DIR = 4'b0001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               goodColl_i,
    input  logic               badColl_i,
    input  logic               button_i,
    input  logic [3:0]         direction_i,
    input  logic               tick_i,
    output logic [3:0]         dir_o,
    output logic               step_o,
    output logic               grow_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [1:0]         state_o
);

    localparam int CW = $clog2(QDEPTH + 1);

    state_t             state_q, state_d;
    logic [3:0]         dir_q, dir_d, dir_prev_q;
    logic               step_q, grow_q, latch_q, latch_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               btn_prev_q, food_prev_q;

    logic               btn_rise, food_rise, dir_evt, run, do_step, start;
    logic               q_push, q_pop, q_clr, q_full, q_empty;
    logic [3:0]         q_head, q_tail, ref_dir;
    logic [CW-1:0]      q_count;

    assign btn_rise  = button_i & ~btn_prev_q;
    assign food_rise = goodColl_i & ~food_prev_q;
    assign dir_evt   = is_onehot(direction_i) && (direction_i != dir_prev_q);
    assign run       = (state_q == RUN);
    assign start     = (state_q == IDLE) & btn_rise;
    assign do_step   = run & tick_i & ~badColl_i;
    assign q_pop     = do_step & ~q_empty;
    // A pop never changes the reference: with one entry the popped head is the tail.
    assign ref_dir   = (q_count != '0) ? q_tail : dir_q;
    assign q_push    = run & ~badColl_i & dir_evt & (direction_i != ref_dir)
                     & (direction_i != dir_reverse(ref_dir)) & (~q_full | q_pop);
    assign q_clr     = start | (run & badColl_i);

    dir_fifo #(.DEPTH(QDEPTH), .WIDTH(4)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (q_clr),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .data_i  (direction_i),
        .head_o  (q_head),
        .tail_o  (q_tail),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // Next-state, heading, score and grow-latch decisions.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        score_d = score_q;
        latch_d = latch_q;
        unique case (state_q)
            IDLE:  if (btn_rise) state_d = RUN;
            RUN:   if (badColl_i) state_d = OVER;
                   else if (btn_rise) state_d = PAUSE;
            PAUSE: if (btn_rise) state_d = RUN;
            OVER:  if (btn_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (start) begin
            dir_d   = INIT_DIR;
            score_d = '0;
            latch_d = 1'b0;
        end
        if ((state_q == OVER) && btn_rise) score_d = '0;
        if (q_pop) dir_d = q_head;
        // Step consumes the latch first so coincident food lands on the next step.
        if (do_step) latch_d = 1'b0;
        if (run && food_rise) begin
            latch_d = 1'b1;
            if (score_q != {SCORE_W{1'b1}}) score_d = score_q + 1'b1;
        end
    end

    // Registered state, outputs and edge-history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dir_q       <= INIT_DIR;
            step_q      <= 1'b0;
            grow_q      <= 1'b0;
            latch_q     <= 1'b0;
            score_q     <= '0;
            btn_prev_q  <= 1'b0;
            food_prev_q <= 1'b0;
            dir_prev_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            step_q      <= do_step;
            grow_q      <= do_step & latch_q;
            latch_q     <= latch_d;
            score_q     <= score_d;
            btn_prev_q  <= button_i;
            food_prev_q <= goodColl_i;
            dir_prev_q  <= direction_i;
        end
    end

    assign dir_o   = dir_q;
    assign step_o  = step_q;
    assign grow_o  = grow_q;
    assign score_o = score_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the game rules.
module tb_snake_game_ctrl;

    localparam int         QD   = 2;
    localparam int         SW   = 2;
    localparam logic [3:0] INIT = 4'b0001;

    logic          clk = 1'b0;
    logic          rst = 1'b0, goodColl = 1'b0, badColl = 1'b0, button = 1'b0, tick = 1'b0;
    logic [3:0]    direction = 4'd0;
    logic [3:0]    dir_o;
    logic          step_o, grow_o;
    logic [SW-1:0] score_o;
    logic [1:0]    state_o;

    always #5 clk = ~clk;

    snake_game_ctrl #(.QDEPTH(QD), .SCORE_W(SW), .INIT_DIR(INIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .goodColl_i  (goodColl),
        .badColl_i   (badColl),
        .button_i    (button),
        .direction_i (direction),
        .tick_i      (tick),
        .dir_o       (dir_o),
        .step_o      (step_o),
        .grow_o      (grow_o),
        .score_o     (score_o),
        .state_o     (state_o)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: 0=idle 1=run 2=pause 3=over
    int         m_state = 0;
    int         m_score = 0;
    logic [3:0] m_dir   = INIT;
    logic [3:0] m_q[$];
    bit         m_latch = 0, m_step = 0, m_grow = 0, p_btn = 0, p_food = 0;
    logic [3:0] p_dir   = 4'd0;

    function automatic logic [3:0] opposite(input logic [3:0] d);
        case (d)
            4'b1000: return 4'b0100;
            4'b0100: return 4'b1000;
            4'b0010: return 4'b0001;
            4'b0001: return 4'b0010;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit g, input bit b, input bit bt,
                              input logic [3:0] d, input bit t);
        bit brise, frise, devt;
        logic [3:0] refd;
        if (r) begin
            m_state = 0; m_score = 0; m_dir = INIT; m_q.delete();
            m_latch = 0; m_step = 0; m_grow = 0; p_btn = 0; p_food = 0; p_dir = 0;
            return;
        end
        brise = bt && !p_btn;
        frise = g && !p_food;
        devt  = ($countones(d) == 1) && (d != p_dir);
        m_step = 0;
        m_grow = 0;
        case (m_state)
            0: if (brise) begin
                m_state = 1; m_score = 0; m_q.delete(); m_dir = INIT; m_latch = 0;
            end
            1: begin
                if (t && !b) begin
                    m_step = 1;
                    m_grow = m_latch;
                    m_latch = 0;
                    if (m_q.size() > 0) m_dir = m_q.pop_front();
                end
                if (frise) begin
                    if (m_score < (1 << SW) - 1) m_score++;
                    m_latch = 1;
                end
                if (devt && !b) begin
                    refd = (m_q.size() > 0) ? m_q[$] : m_dir;
                    if (d != refd && d != opposite(refd) && m_q.size() < QD) m_q.push_back(d);
                end
                if (b) begin
                    m_state = 3; m_q.delete();
                end else if (brise) m_state = 2;
            end
            2: if (brise) m_state = 1;
            default: if (brise) begin
                m_state = 0; m_score = 0;
            end
        endcase
        p_btn = bt; p_food = g; p_dir = d;
    endtask

    // One clock: apply inputs, advance the model, sample 1 time unit after the edge.
    task automatic cyc(input bit r, input bit g, input bit b, input bit bt,
                       input logic [3:0] d, input bit t);
        rst = r; goodColl = g; badColl = b; button = bt; direction = d; tick = t;
        model_step(r, g, b, bt, d, t);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 4'd0, 0);
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_o); end
        checks++; if (dir_o !== INIT) begin errors++; $display("FAIL reset_dir: got %b want %b", dir_o, INIT); end
        checks++; if (step_o !== 1'b0 || grow_o !== 1'b0) begin errors++; $display("FAIL reset_step_grow: got %b%b want 00", step_o, grow_o); end
        checks++; if (score_o !== '0) begin errors++; $display("FAIL reset_score: got %0d want 0", score_o); end
        cyc(0, 0, 0, 0, 4'd0, 0);
    endtask

    task automatic test_start();
        cyc(0, 0, 0, 1, 4'd0, 0);
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL start_state: got %0d want 1", state_o); end
        cyc(0, 0, 0, 0, 4'd0, 0);
        checks++; if (step_o !== 1'b0) begin errors++; $display("FAIL start_nostep: got %b want 0", step_o); end
        cyc(0, 0, 0, 0, 4'd0, 1);
        checks++; if (step_o !== 1'b1 || dir_o !== 4'b0001) begin errors++; $display("FAIL start_step: got step=%b dir=%b want step=1 dir=0001", step_o, dir_o); end
        checks++; if (score_o !== '0) begin errors++; $display("FAIL start_score: got %0d want 0", score_o); end
        cyc(0, 0, 0, 0, 4'd0, 0);
        checks++; if (step_o !== 1'b0) begin errors++; $display("FAIL step_one_cycle: got %b want 0", step_o); end
    endtask

    task automatic test_reverse();
        cyc(0, 0, 0, 0, 4'b0010, 0);
        cyc(0, 0, 0, 0, 4'b0001, 0);
        cyc(0, 0, 0, 0, 4'b0000, 0);
        cyc(0, 0, 0, 0, 4'b0000, 1);
        checks++; if (step_o !== 1'b1 || dir_o !== 4'b0001) begin errors++; $display("FAIL reverse_drop: got step=%b dir=%b want step=1 dir=0001", step_o, dir_o); end
    endtask

    task automatic test_turns();
        cyc(0, 0, 0, 0, 4'b1000, 0);
        cyc(0, 0, 0, 0, 4'b0010, 0);
        cyc(0, 0, 0, 0, 4'b0000, 0);
        checks++; if (dir_o !== 4'b0001) begin errors++; $display("FAIL turn_before_tick: got %b want 0001", dir_o); end
        cyc(0, 0, 0, 0, 4'b0000, 1);
        checks++; if (step_o !== 1'b1 || dir_o !== 4'b1000) begin errors++; $display("FAIL turn_first: got step=%b dir=%b want 1/1000", step_o, dir_o); end
        cyc(0, 0, 0, 0, 4'b0000, 1);
        checks++; if (step_o !== 1'b1 || dir_o !== 4'b0010) begin errors++; $display("FAIL turn_second: got step=%b dir=%b want 1/0010", step_o, dir_o); end
        cyc(0, 0, 0, 0, 4'b0000, 1);
        checks++; if (step_o !== 1'b1 || dir_o !== 4'b0010) begin errors++; $display("FAIL turn_queue_empty: got step=%b dir=%b want 1/0010", step_o, dir_o); end
    endtask

    task automatic test_full();
        cyc(0, 0, 0, 0, 4'b1000, 0);
        cyc(0, 0, 0, 0, 4'b0001, 0);
        cyc(0, 0, 0, 0, 4'b0100, 0);
        cyc(0, 0, 0, 0, 4'b1000, 1);
        checks++; if (step_o !== 1'b1 || dir_o !== 4'b1000) begin errors++; $display("FAIL full_pop: got step=%b dir=%b want 1/1000", step_o, dir_o); end
        cyc(0, 0, 0, 0, 4'b0000, 1);
        checks++; if (dir_o !== 4'b0001) begin errors++; $display("FAIL full_second: got %b want 0001", dir_o); end
        cyc(0, 0, 0, 0, 4'b0000, 1);
        checks++; if (dir_o !== 4'b1000) begin errors++; $display("FAIL full_pushpop_accept: got %b want 1000", dir_o); end
        cyc(0, 0, 0, 0, 4'b0000, 1);
        checks++; if (dir_o !== 4'b1000) begin errors++; $display("FAIL full_third_dropped: got %b want 1000", dir_o); end
    endtask

    task automatic test_food();
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0, 0, 4'd0, 0);
            cyc(0, 0, 0, 0, 4'd0, 0);
        end
        checks++; if (score_o !== 2'd2) begin errors++; $display("FAIL food_score2: got %0d want 2", score_o); end
        cyc(0, 0, 0, 0, 4'd0, 1);
        checks++; if (step_o !== 1'b1 || grow_o !== 1'b1) begin errors++; $display("FAIL food_grow_first: got step=%b grow=%b want 1/1", step_o, grow_o); end
        cyc(0, 0, 0, 0, 4'd0, 1);
        checks++; if (grow_o !== 1'b0) begin errors++; $display("FAIL food_grow_once: got %b want 0", grow_o); end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 4'd0, 0);
            cyc(0, 0, 0, 0, 4'd0, 0);
        end
        checks++; if (score_o !== 2'd3) begin errors++; $display("FAIL food_saturate: got %0d want 3", score_o); end
        cyc(0, 0, 0, 0, 4'd0, 1);
        cyc(0, 1, 0, 0, 4'd0, 1);
        checks++; if (step_o !== 1'b1 || grow_o !== 1'b0) begin errors++; $display("FAIL food_coincident_now: got step=%b grow=%b want 1/0", step_o, grow_o); end
        cyc(0, 0, 0, 0, 4'd0, 1);
        checks++; if (grow_o !== 1'b1) begin errors++; $display("FAIL food_coincident_next: got %b want 1", grow_o); end
    endtask

    task automatic test_pause();
        cyc(0, 0, 0, 1, 4'd0, 0);
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL pause_enter: got %0d want 2", state_o); end
        cyc(0, 0, 0, 0, 4'd0, 1);
        checks++; if (step_o !== 1'b0) begin errors++; $display("FAIL pause_tick_ignored: got %b want 0", step_o); end
        cyc(0, 0, 1, 0, 4'd0, 0);
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL pause_coll_ignored: got %0d want 2", state_o); end
        cyc(0, 0, 0, 0, 4'd0, 0);
        cyc(0, 0, 0, 1, 4'd0, 0);
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL pause_resume: got %0d want 1", state_o); end
        cyc(0, 0, 0, 0, 4'd0, 0);
    endtask

    task automatic test_collision();
        cyc(0, 0, 1, 0, 4'd0, 1);
        checks++; if (state_o !== 2'd3 || step_o !== 1'b0) begin errors++; $display("FAIL coll_over: got state=%0d step=%b want 3/0", state_o, step_o); end
        cyc(0, 0, 0, 0, 4'd0, 1);
        checks++; if (step_o !== 1'b0 || score_o !== 2'd3) begin errors++; $display("FAIL over_hold: got step=%b score=%0d want 0/3", step_o, score_o); end
        cyc(0, 0, 0, 1, 4'd0, 0);
        checks++; if (state_o !== 2'd0 || score_o !== 2'd0) begin errors++; $display("FAIL over_to_idle: got state=%0d score=%0d want 0/0", state_o, score_o); end
        cyc(0, 0, 0, 0, 4'd0, 0);
    endtask

    task automatic test_reset_mid();
        cyc(0, 0, 0, 1, 4'd0, 0);
        cyc(0, 0, 0, 0, 4'd0, 0);
        cyc(0, 0, 0, 0, 4'b1000, 0);
        cyc(0, 1, 0, 0, 4'd0, 0);
        cyc(1, 1, 0, 1, 4'd0, 1);
        checks++; if (state_o !== 2'd0 || dir_o !== INIT || step_o !== 1'b0 || grow_o !== 1'b0 || score_o !== 2'd0)
            begin errors++; $display("FAIL reset_mid: got state=%0d dir=%b step=%b grow=%b score=%0d want 0/%b/0/0/0", state_o, dir_o, step_o, grow_o, score_o, INIT); end
        cyc(0, 0, 0, 0, 4'd0, 0);
        cyc(0, 0, 0, 1, 4'd0, 0);
        cyc(0, 0, 0, 0, 4'd0, 1);
        checks++; if (step_o !== 1'b1 || dir_o !== INIT || grow_o !== 1'b0) begin errors++; $display("FAIL reset_mid_cleared: got step=%b dir=%b grow=%b want 1/%b/0", step_o, dir_o, grow_o, INIT); end
    endtask

    task automatic test_random();
        logic [3:0] d;
        bit r, g, b, bt, t;
        int sel;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            b  = ($urandom_range(0, 39) == 0);
            bt = ($urandom_range(0, 5) == 0);
            g  = ($urandom_range(0, 3) == 0);
            t  = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 3);
            if (sel < 2) d = 4'b0001 << $urandom_range(0, 3);
            else if (sel == 2) d = 4'd0;
            else d = 4'($urandom_range(0, 15));
            cyc(r, g, b, bt, d, t);
            checks++; if (state_o !== 2'(m_state)) begin errors++; $display("FAIL rand_state @%0d: got %0d want %0d", i, state_o, m_state); end
            checks++; if (dir_o !== m_dir) begin errors++; $display("FAIL rand_dir @%0d: got %b want %b", i, dir_o, m_dir); end
            checks++; if (step_o !== m_step) begin errors++; $display("FAIL rand_step @%0d: got %b want %b", i, step_o, m_step); end
            checks++; if (grow_o !== m_grow) begin errors++; $display("FAIL rand_grow @%0d: got %b want %b", i, grow_o, m_grow); end
            checks++; if (score_o !== SW'(m_score)) begin errors++; $display("FAIL rand_score @%0d: got %0d want %0d", i, score_o, m_score); end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_reverse();
        test_turns();
        test_full();
        test_food();
        test_pause();
        test_collision();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
